// File: rtl/mod_mul.sv
// Sequential modular multiplier over the secp256k1 field: product = (op_a * op_b) mod P.
// Interleaved MSB-first double-and-add, one multiplier bit per clock; start/done handshake with busy.
module mod_mul #(
    parameter int               WIDTH = 256,
    parameter logic [WIDTH-1:0] P     = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] product,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH:0] P_EXT = {1'b0, P};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REDUCE = 3'd1,
        LOOP   = 3'd2,
        FINISH = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_r, a_nxt;
    logic [WIDTH-1:0] b_r, b_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] product_nxt;
    logic             busy_nxt, done_nxt;

    // One double-and-add step; both sums kept WIDTH+1 bits wide so the carry feeds the compare.
    logic [WIDTH:0]   dbl_raw, sum_raw;
    logic [WIDTH-1:0] dbl_w, sum_w;

    assign dbl_raw = {acc, 1'b0};
    assign dbl_w   = (dbl_raw >= P_EXT) ? WIDTH'(dbl_raw - P_EXT) : dbl_raw[WIDTH-1:0];
    assign sum_raw = {1'b0, dbl_w} + {1'b0, a_r};
    assign sum_w   = (sum_raw >= P_EXT) ? WIDTH'(sum_raw - P_EXT) : sum_raw[WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            a_r     <= a_nxt;
            b_r     <= b_nxt;
            acc     <= acc_nxt;
            cnt     <= cnt_nxt;
            product <= product_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        a_nxt       = a_r;
        b_nxt       = b_r;
        acc_nxt     = acc;
        cnt_nxt     = cnt;
        product_nxt = product;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    a_nxt     = op_a;
                    b_nxt     = op_b;
                    acc_nxt   = '0;
                    cnt_nxt   = CW'(WIDTH - 1);
                    busy_nxt  = 1'b1;
                    state_nxt = REDUCE;
                end
            end
            REDUCE: begin
                // P > 2^(WIDTH-1) bounds op_a below 2P, so one subtraction is enough.
                if (a_r >= P) a_nxt = a_r - P;
                state_nxt = LOOP;
            end
            LOOP: begin
                acc_nxt = b_r[cnt] ? sum_w : dbl_w;
                if (cnt == '0) state_nxt = FINISH;
                else           cnt_nxt   = cnt - 1'b1;
            end
            FINISH: begin
                product_nxt = acc;
                done_nxt    = 1'b1;
                state_nxt   = DONE;
            end
            DONE: begin
                // done is high for this whole state; start is deliberately not sampled here.
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mod_mul.sv
// Randomised and directed bench for mod_mul against a plain-arithmetic reference (a*b mod P).
module tb_mod_mul;
    localparam int               WIDTH = 256;
    localparam logic [WIDTH-1:0] P     = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    localparam int               LAT   = WIDTH + 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] product;
    logic             busy, done;

    int checks = 0;
    int errors = 0;

    mod_mul #(.WIDTH(WIDTH), .P(P)) dut (
        .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .product(product), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] full;
        full = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        return WIDTH'(full % {{WIDTH{1'b0}}, P});
    endfunction

    // Issues one operation from just after a clock edge and follows it to the done pulse.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int n;
        int busy_low;
        logic [WIDTH-1:0] exp;
        exp   = ref_mul(a, b);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        n        = 0;
        busy_low = 0;
        while (n < LAT + 50) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
            if (!busy) busy_low++;
        end
        check({tag, " latency"}, WIDTH'(n), WIDTH'(LAT));
        check({tag, " product"}, product, exp);
        check({tag, " busy_during"}, WIDTH'(busy_low), '0);
        check({tag, " busy_at_done"}, WIDTH'(busy), WIDTH'(1));
        @(posedge clk);
        #1;
        check({tag, " done_fall"}, WIDTH'(done), '0);
        check({tag, " busy_fall"}, WIDTH'(busy), '0);
    endtask

    initial begin
        logic [WIDTH:0]   pp1;
        logic [WIDTH-1:0] inv2;
        int               n;
        int               ndone;

        reset = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset product", product, '0);
        check("reset busy", WIDTH'(busy), '0);
        check("reset done", WIDTH'(done), '0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_op("2x3", 256'd2, 256'd3);
        check("2x3 value", product, 256'd6);
        run_op("pm1sq", P - 1, P - 1);
        check("pm1sq value", product, 256'd1);
        pp1  = {1'b0, P} + 1'b1;
        inv2 = pp1[WIDTH:1];
        run_op("inv2", 256'd2, inv2);
        check("inv2 value", product, 256'd1);
        run_op("reduce", P + 256'd5, 256'd2);
        check("reduce value", product, 256'd10);
        run_op("a_eq_p", P, 256'd12345);
        check("a_eq_p value", product, '0);
        run_op("zero", '0, '1);
        check("zero value", product, '0);

        for (int i = 0; i < 8; i++) begin
            logic [WIDTH-1:0] ra, rb;
            for (int w = 0; w < WIDTH / 32; w++) begin
                ra[w*32 +: 32] = $urandom;
                rb[w*32 +: 32] = $urandom;
            end
            if (i == 0) ra = P + (ra >> 224);
            run_op("random", ra, rb);
        end

        // Second start while busy must be ignored.
        op_a  = 256'd7;
        op_b  = 256'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n     = 0;
        ndone = 0;
        while (n < LAT + 50) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 99) begin
                op_a  = 256'd4;
                op_b  = 256'd4;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                break;
            end
        end
        check("ignore latency", WIDTH'(n), WIDTH'(LAT));
        check("ignore product", product, 256'd63);
        check("ignore ndone", WIDTH'(ndone), WIDTH'(1));
        // Start held through the done cycle must not be taken there.
        op_a  = 256'd3;
        op_b  = 256'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("done cycle start busy", WIDTH'(busy), '0);
        run_op("b2b", 256'd4, 256'd4);
        check("b2b value", product, 256'd16);

        // Asynchronous reset mid-operation.
        op_a  = 256'd3;
        op_b  = 256'd11;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("abort product", product, '0);
        check("abort busy", WIDTH'(busy), '0);
        check("abort done", WIDTH'(done), '0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < LAT + 20; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        check("abort no done", WIDTH'(ndone), '0);
        run_op("5x5", 256'd5, 256'd5);
        check("5x5 value", product, 256'd25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
